instr_encoder_loader: RTL and testbench

Encoder counterpart to the core's main opcode decoder. Accepts instruction fields (lw, sw, R-type, beq) over a valid/ready stream and packs them into 32-bit RV32I words. Writes the words sequentially into instruction memory through a registered write port with backpressure.
Used to preload IMEM before the pipeline is released, or to patch IMEM while the pipeline is stalled.

---
 rtl/instr_encoder_loader.sv | 156 +++++++++++++++
 tb/tb_instr_encoder_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Packs lw/sw/R-type/beq fields into RV32I words and streams them into IMEM
// through a one-entry registered write port with backpressure.
module instr_encoder_loader #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_instr,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic [12:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_wready,
  output logic              err,
  output logic [7:0]        err_count
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_num;
  logic [CNT_W-1:0]    r_issued;
  logic [CNT_W-1:0]    r_written;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_err;
  logic [7:0]          r_err_count;

  logic [31:0]         w_word;
  logic                w_legal;
  logic                w_xfer;
  logic                w_accept;
  logic                w_reject;
  logic                w_wr_done;
  logic                w_last_write;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    w_word  = '0;
    w_legal = 1'b0;
    unique case (op_sel)
      2'd0: begin
        w_word  = {imm[11:0], rs1, funct3, rd, OP_LW};
        w_legal = (imm[12] == imm[11]);
      end
      2'd1: begin
        w_word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_SW};
        w_legal = (imm[12] == imm[11]);
      end
      2'd2: begin
        w_word  = {1'b0, funct7_5, 5'b00000, rs2, rs1, funct3, rd, OP_R};
        w_legal = 1'b1;
      end
      default: begin
        w_word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BEQ};
        w_legal = ~imm[0];
      end
    endcase
  end

  // The output register is the only buffer: accept a new word only if the
  // slot is empty or is being drained this same cycle.
  assign in_ready     = (r_state == S_LOAD) && (r_issued < r_num) &&
                        (!r_mem_we || mem_wready);
  assign w_xfer       = in_valid & in_ready;
  assign w_accept     = w_xfer & w_legal;
  assign w_reject     = w_xfer & ~w_legal;
  assign w_wr_done    = r_mem_we & mem_wready;
  assign w_last_write = w_wr_done && ((r_written + 1'b1) == r_num);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_next = (num_instr == '0) ? S_DONE : S_LOAD;
      S_LOAD:  if (w_last_write) w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every register here is a plain flop, so all of them take the async
  // reset; a pending word is discarded rather than completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num       <= '0;
      r_issued    <= '0;
      r_written   <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err    <= w_reject;
      r_mem_we <= w_accept | (r_mem_we & ~mem_wready);
      if (r_state == S_IDLE && start) begin
        r_num       <= num_instr;
        r_issued    <= '0;
        r_written   <= '0;
        r_err_count <= '0;
        r_mem_addr  <= base_addr;
      end else begin
        if (w_wr_done) begin
          r_written  <= r_written + 1'b1;
          r_mem_addr <= r_mem_addr + ADDR_W'(4);
        end
        if (w_accept) begin
          r_issued    <= r_issued + 1'b1;
          r_mem_wdata <= w_word;
        end
        if (w_reject && r_err_count != 8'hFF) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end
    end
  end

  assign busy      = (r_state == S_LOAD);
  assign done      = (r_state == S_DONE);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign err       = r_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: a session-level model checks
// every cycle, and directed sessions pin written words to literal values.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  num_instr;
  logic        busy, done, in_valid, in_ready;
  logic [1:0]  op_sel;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [12:0] imm;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_wready;
  logic        err;
  logic [7:0]  err_count;

  instr_encoder_loader #(.ADDR_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_instr(num_instr), .busy(busy), .done(done), .in_valid(in_valid),
    .in_ready(in_ready), .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7_5(funct7_5), .imm(imm), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wready(mem_wready),
    .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Session-level model: phase 0 idle, 1 loading, 2 done.
  int          m_phase, m_num, m_issued, m_written, m_errcnt;
  logic [31:0] m_base;
  bit          m_err;
  logic [31:0] q_addr[$], q_data[$];
  logic [31:0] log_addr[$], log_data[$];
  int          log_cyc[$];
  int          done_cnt = 0, err_cnt = 0, done_cyc = 0;

  function automatic logic [31:0] enc(input int op, input int r_d, input int r1,
                                      input int r2, input int f3, input int f7, input int im);
    int w;
    case (op)
      0: w = ((im & 'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (r_d << 7) | 'h03;
      1: w = (((im >> 5) & 'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) |
             ((im & 'h1F) << 7) | 'h23;
      2: w = ((f7 != 0) ? ('h20 << 25) : 0) | (r2 << 20) | (r1 << 15) | (f3 << 12) |
             (r_d << 7) | 'h33;
      default: w = (((im >> 12) & 1) << 31) | (((im >> 5) & 'h3F) << 25) | (r2 << 20) |
                   (r1 << 15) | (f3 << 12) | (((im >> 1) & 'hF) << 8) |
                   (((im >> 11) & 1) << 7) | 'h63;
    endcase
    return 32'(w);
  endfunction

  function automatic bit legal(input int op, input int im);
    if (op <= 1) return (im >= -2048) && (im <= 2047);
    if (op == 2) return 1'b1;
    return (im % 2) == 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_num = 0; m_issued = 0; m_written = 0; m_errcnt = 0;
    m_base = '0; m_err = 0;
    q_addr.delete(); q_data.delete();
  endtask

  always @(negedge clk) begin
    bit exp_rdy, pend, nerr;
    int im;
    if (!rst_n) model_reset();
    pend    = (q_addr.size() > 0);
    exp_rdy = (m_phase == 1) && (m_issued < m_num) && (!pend || mem_wready);
    check("busy", busy, m_phase == 1);
    check("done", done, m_phase == 2);
    check("err", err, m_err);
    check("err_count", err_count, m_errcnt);
    check("mem_we", mem_we, pend);
    check("in_ready", in_ready, exp_rdy);
    if (pend) begin
      check("mem_addr", mem_addr, q_addr[0]);
      check("mem_wdata", mem_wdata, q_data[0]);
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) err_cnt++;
    if (rst_n) begin
      nerr = 0;
      case (m_phase)
        0: if (start) begin
          m_base = base_addr; m_num = int'(num_instr);
          m_issued = 0; m_written = 0; m_errcnt = 0;
          m_phase = (num_instr == 0) ? 2 : 1;
        end
        1: begin
          if (pend && mem_wready) begin
            log_addr.push_back(mem_addr); log_data.push_back(mem_wdata);
            log_cyc.push_back(cyc);
            void'(q_addr.pop_front()); void'(q_data.pop_front());
            m_written++;
            if (m_written == m_num) m_phase = 2;
          end
          if (in_valid && exp_rdy) begin
            im = int'($signed(imm));
            if (legal(int'(op_sel), im)) begin
              q_addr.push_back(m_base + 32'(4 * m_issued));
              q_data.push_back(enc(int'(op_sel), int'(rd), int'(rs1), int'(rs2),
                                   int'(funct3), int'(funct7_5), im));
              m_issued++;
            end else begin
              nerr = 1;
              if (m_errcnt < 255) m_errcnt++;
            end
          end
        end
        default: m_phase = 0;
      endcase
      m_err = nerr;
    end
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic begin_session(input logic [31:0] base, input logic [7:0] n);
    start = 1; base_addr = base; num_instr = n;
    cycle();
    start = 0;
  endtask

  task automatic send(input int op, input int r_d, input int r1, input int r2,
                      input int f3, input int f7, input int im);
    bit ok = 0;
    op_sel = 2'(op); rd = 5'(r_d); rs1 = 5'(r1); rs2 = 5'(r2);
    funct3 = 3'(f3); funct7_5 = 1'(f7); imm = 13'(im);
    in_valid = 1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      cycle();
    end
    in_valid = 0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n0 = done_cnt;
    int t  = 0;
    while (done_cnt == n0 && t < 200) begin @(posedge clk); t++; end
    #1;
    check("done_pulses", done_cnt - n0, 1);
  endtask

  task automatic three_word_session();
    send(1, 0, 2, 5, 2, 0, 12);
    send(2, 3, 1, 2, 0, 1, 0);
    send(3, 0, 1, 2, 0, 0, -8);
  endtask

  initial begin
    int b, e0;
    rst_n = 0; start = 0; base_addr = 0; num_instr = 0; in_valid = 0;
    op_sel = 0; rd = 0; rs1 = 0; rs2 = 0; funct3 = 0; funct7_5 = 0; imm = 0;
    mem_wready = 1;
    model_reset();
    repeat (3) cycle();
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1;
    cycle();

    // Single lw
    b = log_addr.size();
    begin_session(32'h100, 8'd1);
    send(0, 5, 2, 0, 2, 0, 8);
    wait_done();
    check("t1_count", log_addr.size() - b, 1);
    check("t1_addr", log_addr[b], 32'h100);
    check("t1_data", log_data[b], 32'h00812283);
    check("t1_done_lat", done_cyc - log_cyc[b], 1);

    // sw, R, beq back-to-back
    b = log_addr.size();
    begin_session(32'h100, 8'd3);
    three_word_session();
    wait_done();
    check("t2_count", log_addr.size() - b, 3);
    check("t2_d0", log_data[b],   32'h00512623);
    check("t2_d1", log_data[b+1], 32'h402081B3);
    check("t2_d2", log_data[b+2], 32'hFE208CE3);
    check("t2_a2", log_addr[b+2], 32'h108);
    check("t2_gap01", log_cyc[b+1] - log_cyc[b], 1);
    check("t2_gap12", log_cyc[b+2] - log_cyc[b+1], 1);

    // Same session with 3 stall cycles on the 2nd word
    b = log_addr.size();
    begin_session(32'h100, 8'd3);
    fork
      three_word_session();
      begin
        for (int t = 0; t < 100 && log_addr.size() < b + 1; t++) @(posedge clk);
        #1 mem_wready = 0;
        repeat (3) cycle();
        mem_wready = 1;
      end
    join
    wait_done();
    check("t3_count", log_addr.size() - b, 3);
    check("t3_d1", log_data[b+1], 32'h402081B3);
    check("t3_a1", log_addr[b+1], 32'h104);
    check("t3_d2", log_data[b+2], 32'hFE208CE3);
    check("t3_a2", log_addr[b+2], 32'h108);
    check("t3_stall", log_cyc[b+1] - log_cyc[b], 4);

    // Rejections then a legal lw
    b = log_addr.size(); e0 = err_cnt;
    begin_session(32'h200, 8'd1);
    send(3, 0, 1, 2, 0, 0, 5);
    send(0, 5, 2, 0, 2, 0, 2048);
    send(0, 5, 2, 0, 2, 0, 8);
    wait_done();
    check("t4_err_pulses", err_cnt - e0, 2);
    check("t4_err_count", err_count, 8'd2);
    check("t4_count", log_addr.size() - b, 1);
    check("t4_addr", log_addr[b], 32'h200);
    check("t4_data", log_data[b], 32'h00812283);

    // Address wrap
    b = log_addr.size();
    begin_session(32'hFFFFFFFC, 8'd2);
    send(0, 1, 0, 0, 2, 0, 0);
    send(1, 0, 0, 1, 2, 0, -4);
    wait_done();
    check("t5_a0", log_addr[b],   32'hFFFFFFFC);
    check("t5_a1", log_addr[b+1], 32'h0);
    check("t5_d1", log_data[b+1], 32'hFE102E23);

    // Reset with a pending, stalled write
    b = log_addr.size();
    mem_wready = 0;
    begin_session(32'h300, 8'd2);
    send(0, 1, 0, 0, 2, 0, 4);
    cycle();
    check("t6_we_before", mem_we, 1'b1);
    rst_n = 0;
    #1;
    check("t6_we_async", mem_we, 1'b0);
    check("t6_rdy_async", in_ready, 1'b0);
    repeat (2) cycle();
    rst_n = 1;
    mem_wready = 1;
    repeat (2) cycle();
    check("t6_busy", busy, 1'b0);
    check("t6_rdy", in_ready, 1'b0);
    check("t6_no_write", log_addr.size() - b, 0);

    // Zero-length session
    begin_session(32'h0, 8'd0);
    wait_done();
    check("t7_no_write", log_addr.size() - b, 0);
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
